// File: rtl/packet_deflitizer.sv
// Unpacks 128-bit NoC flits into a stream of 32-bit CPU words with header/last marking.
// Optional ordering check enabled by defining DEFLIT_PROTOCOL_CHECK_EN.
module packet_deflitizer (
  input  logic         nocclk,
  input  logic         rst,
  input  logic [127:0] poped_flit,
  input  logic         poped_flit_valid,
  output logic         poped_flit_ready,
  output logic [31:0]  data_out,
  output logic         data_out_valid,
  input  logic         data_out_ready,
  output logic         data_out_last,
  output logic         data_out_is_header,
  output logic         in_packet,
  output logic         protocol_error
);

  typedef enum logic {IDLE, UNPACK} state_t;
  typedef enum logic [1:0] {
    T_HEAD     = 2'b00,
    T_BODY     = 2'b01,
    T_TAIL     = 2'b10,
    T_HEADTAIL = 2'b11
  } flit_type_t;

  state_t       state, state_next;
  logic [127:0] flit;
  logic [1:0]   idx, idx_next;
  logic         in_packet_next;

  // Head and headtail carry a header word in front of their payload.
  function automatic logic has_header(input logic [127:0] f);
    return f[127] == f[126];
  endfunction

  function automatic logic [2:0] word_count(input logic [127:0] f);
    return {1'b0, f[125:124]} + {2'b00, has_header(f)};
  endfunction

  flit_type_t in_type;
  logic       in_hdr;
  logic [2:0] in_words;
  logic       held_hdr;
  logic [2:0] held_words;
  logic       final_word;
  logic       transfer;
  logic       pop;
  logic       err;

  assign in_type    = flit_type_t'(poped_flit[127:126]);
  assign in_hdr     = has_header(poped_flit);
  assign in_words   = word_count(poped_flit);
  assign held_hdr   = has_header(flit);
  assign held_words = word_count(flit);
  assign final_word = ({1'b0, idx} == held_words - 3'd1);
  assign transfer   = (state == UNPACK) && data_out_ready;

  assign poped_flit_ready = (state == IDLE) || (transfer && final_word);
  assign pop              = poped_flit_valid && poped_flit_ready;

`ifdef DEFLIT_PROTOCOL_CHECK_EN
  logic error_pulse;
  assign err = pop && (in_hdr ? in_packet : !in_packet);
  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) error_pulse <= 1'b0;
    else     error_pulse <= err;
  end
  assign protocol_error = error_pulse;
`else
  assign err            = 1'b0;
  assign protocol_error = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next     = state;
    idx_next       = idx;
    in_packet_next = in_packet;
    if (transfer) begin
      if (final_word) begin
        state_next = IDLE;
        if (flit[127]) in_packet_next = 1'b0;
      end else begin
        idx_next = idx + 2'd1;
      end
    end
    // A pop on the final transfer overrides the return to IDLE for back-to-back flits.
    if (pop && !err) begin
      if (in_type == T_HEAD)
        in_packet_next = 1'b1;
      else if (in_type == T_TAIL && in_words == 3'd0)
        in_packet_next = 1'b0;
      if (in_words != 3'd0) begin
        state_next = UNPACK;
        idx_next   = 2'd0;
      end
    end
  end

  always_ff @(posedge nocclk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      in_packet <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      in_packet <= in_packet_next;
    end
  end

  // NOTE: the flit holder is reset too; it is a single register, not a memory array.
  always_ff @(posedge nocclk or posedge rst) begin
    if (rst)
      flit <= '0;
    else if (pop && !err && in_words != 3'd0)
      flit <= poped_flit;
  end

  logic [1:0]  pay_idx;
  logic [31:0] payload;

  assign pay_idx = held_hdr ? idx - 2'd1 : idx;

  always_comb begin
    payload = flit[95:64];
    case (pay_idx)
      2'd0:    payload = flit[31:0];
      2'd1:    payload = flit[63:32];
      default: payload = flit[95:64];
    endcase
  end

  assign data_out_valid     = (state == UNPACK);
  assign data_out_is_header = data_out_valid && held_hdr && (idx == 2'd0);
  assign data_out_last      = data_out_valid && final_word && flit[127];
  assign data_out           = !data_out_valid    ? 32'h0 :
                              data_out_is_header ? flit[127:96] : payload;

endmodule
